// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of the UART byte-buffer transmit
// controller between NREQ message sources, with completion/timeout pulses.
module uart_tx_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [3*NREQ-1:0]    req_bcount,
    input  logic [32*NREQ-1:0]   req_tbuf,
    output logic [NREQ-1:0]      done,
    output logic [NREQ-1:0]      err,
    output logic [NREQ-1:0]      grant,
    output logic [2:0]           bc_bcount,
    output logic [31:0]          bc_tbuf,
    output logic                 bc_start,
    input  logic                 bc_ready,
    output logic                 busy
);

    localparam int unsigned PTR_W  = 3;
    localparam int unsigned IDX_W  = PTR_W + 1;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned CNTX_W = CNT_W + 1;
    localparam int unsigned BC_W   = 3;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MAXN   = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    win_q, win_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NREQ-1:0]     grant_q, grant_d;
    logic [NREQ-1:0]     done_q, done_d;
    logic [NREQ-1:0]     err_q, err_d;
    logic [BC_W-1:0]     bcount_q, bcount_d;
    logic [DATA_W-1:0]   tbuf_q, tbuf_d;
    logic                start_q, start_d;
    logic                busy_q, busy_d;

    logic [MAXN-1:0]     elig;
    logic                found;
    logic [PTR_W-1:0]    sel;
    logic [IDX_W-1:0]    idx;
    logic [BC_W-1:0]     sel_bcount;
    logic [DATA_W-1:0]   sel_tbuf;
    logic [PTR_W-1:0]    ptr_next;
    logic                timeout_hit;

    // A source being released this cycle is not eligible for re-grant
    assign elig = MAXN'(req & ~done_q & ~err_q);

    assign ptr_next    = (win_q == PTR_W'(NREQ - 1)) ? '0 : win_q + PTR_W'(1);
    assign timeout_hit = (CNTX_W'(cnt_q) + CNTX_W'(1)) >= CNTX_W'(TIMEOUT);

    // Round-robin search starting at ptr, first eligible source wins
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = IDX_W'(ptr_q) + IDX_W'(k);
            if (idx >= IDX_W'(NREQ)) begin
                idx = idx - IDX_W'(NREQ);
            end
            if (!found && elig[idx[PTR_W-1:0]]) begin
                found = 1'b1;
                sel   = idx[PTR_W-1:0];
            end
        end
    end

    // Payload of the selected source
    always_comb begin
        sel_bcount = '0;
        sel_tbuf   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (sel == PTR_W'(i)) begin
                sel_bcount = req_bcount[BC_W*i +: BC_W];
                sel_tbuf   = req_tbuf[DATA_W*i +: DATA_W];
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        done_d   = '0;
        err_d    = '0;
        bcount_d = bcount_q;
        tbuf_d   = tbuf_q;
        start_d  = start_q;

        unique case (state_q)
            S_IDLE: begin
                // bc_ready gates selection so a job left in flight across reset drains first
                if (found && bc_ready) begin
                    win_d    = sel;
                    grant_d  = NREQ'(1) << sel;
                    bcount_d = sel_bcount;
                    tbuf_d   = sel_tbuf;
                    if (sel_bcount == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                        start_d = 1'b1;
                        cnt_d   = '0;
                    end
                end
            end
            S_ISSUE: begin
                if (!bc_ready) begin
                    start_d = 1'b0;
                    state_d = S_BUSY;
                end else if (timeout_hit) begin
                    start_d = 1'b0;
                    err_d   = grant_q;
                    grant_d = '0;
                    ptr_d   = ptr_next;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                end
            end
            S_BUSY: begin
                if (bc_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = grant_q;
                grant_d = '0;
                ptr_d   = ptr_next;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            win_q    <= '0;
            cnt_q    <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            err_q    <= '0;
            bcount_q <= '0;
            tbuf_q   <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            err_q    <= err_d;
            bcount_q <= bcount_d;
            tbuf_q   <= tbuf_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
        end
    end

    assign done      = done_q;
    assign err       = err_q;
    assign grant     = grant_q;
    assign bc_bcount = bcount_q;
    assign bc_tbuf   = tbuf_q;
    assign bc_start  = start_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed jobs, grant/completion scoreboard.
module tb_uart_tx_arbiter;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned TIMEOUT = 8;

    typedef struct {
        int          src;
        logic [2:0]  bc;
        logic [31:0] tb;
        bit          is_err;
    } job_t;

    logic                clk        = 1'b0;
    logic                rst_n      = 1'b0;
    logic [NREQ-1:0]     req        = '0;
    logic [3*NREQ-1:0]   req_bcount = '0;
    logic [32*NREQ-1:0]  req_tbuf   = '0;
    logic [NREQ-1:0]     done;
    logic [NREQ-1:0]     err;
    logic [NREQ-1:0]     grant;
    logic [2:0]          bc_bcount;
    logic [31:0]         bc_tbuf;
    logic                bc_start;
    logic                busy;
    logic                bc_ready   = 1'b1;

    int   ctl_cnt   = 0;
    int   ctl_hold  = 3;
    bit   ctl_stuck = 1'b0;
    int   errors    = 0;
    int   checks    = 0;
    bit   sim_done  = 1'b0;
    int   left [NREQ];
    job_t exp_grant [$];
    job_t exp_cmpl  [$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_bcount (req_bcount),
        .req_tbuf   (req_tbuf),
        .done       (done),
        .err        (err),
        .grant      (grant),
        .bc_bcount  (bc_bcount),
        .bc_tbuf    (bc_tbuf),
        .bc_start   (bc_start),
        .bc_ready   (bc_ready),
        .busy       (busy)
    );

    // Buffer controller model: drops ready the edge it samples start, holds it low ctl_hold cycles
    always @(posedge clk) begin
        if (ctl_cnt > 0) begin
            ctl_cnt <= ctl_cnt - 1;
            if (ctl_cnt == 1) bc_ready <= 1'b1;
        end else if (bc_ready && bc_start && !ctl_stuck) begin
            bc_ready <= 1'b0;
            ctl_cnt  <= ctl_hold;
        end
    end

    function automatic logic [3:0] oh(input int s);
        oh = 4'b0001 << s;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic set_src(input int i, input logic [2:0] bc, input logic [31:0] tb);
        req_bcount[3*i +: 3]  = bc;
        req_tbuf[32*i +: 32]  = tb;
    endtask

    task automatic push_job(input int src, input logic [2:0] bc, input logic [31:0] tb, input bit e);
        job_t j;
        j.src = src; j.bc = bc; j.tb = tb; j.is_err = e;
        exp_grant.push_back(j);
        exp_cmpl.push_back(j);
    endtask

    // Waits for n done/err pulses, withdrawing a source's req once its job budget is used
    task automatic wait_jobs(input int n, input int maxc, input string nm);
        int seen = 0;
        for (int c = 0; c < maxc && seen < n; c++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (done[i] || err[i]) begin
                    seen++;
                    if (left[i] > 0) left[i]--;
                    if (left[i] == 0) req[i] = 1'b0;
                end
            end
        end
        chk(nm, 32'(seen), 32'(n));
    endtask

    // Scoreboard monitor: checks every grant rise and every done/err pulse
    task automatic monitor();
        logic [3:0] prev = '0;
        job_t j;
        while (!sim_done) begin
            @(negedge clk);
            if (!rst_n) begin
                prev = '0;
            end else begin
                if (grant != '0 && prev == '0) begin
                    if (exp_grant.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_grant: got 0x%0h expected none", grant);
                    end else begin
                        j = exp_grant.pop_front();
                        chk("sb_grant", 32'(grant), 32'(oh(j.src)));
                        chk("sb_bcount", 32'(bc_bcount), 32'(j.bc));
                        chk("sb_tbuf", bc_tbuf, j.tb);
                        chk("sb_busy", 32'(busy), 32'h1);
                    end
                end
                if ((done | err) != '0) begin
                    if (exp_cmpl.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_completion: got done=0x%0h err=0x%0h expected none", done, err);
                    end else begin
                        j = exp_cmpl.pop_front();
                        chk("sb_done", 32'(done), j.is_err ? 32'h0 : 32'(oh(j.src)));
                        chk("sb_err", 32'(err), j.is_err ? 32'(oh(j.src)) : 32'h0);
                        chk("sb_grant_low", 32'(grant), 32'h0);
                    end
                end
                prev = grant;
            end
        end
    endtask

    task automatic stimulus();
        int starts, td, tr;
        bit low_seen, got;

        // Reset state with all sources already requesting
        for (int i = 0; i < NREQ; i++) begin
            left[i] = 0;
            set_src(i, 3'(i + 1), 32'hA000_0000 + 32'(i));
        end
        req = 4'b1111;
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_start", 32'(bc_start), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_tbuf", bc_tbuf, 32'h0);
        chk("rst_bcount", 32'(bc_bcount), 32'h0);

        // Fairness: expected order 0,1,2,3,0,1
        ctl_hold = 3;
        left = '{2, 2, 1, 1};
        push_job(0, 3'd1, 32'hA000_0000, 1'b0);
        push_job(1, 3'd2, 32'hA000_0001, 1'b0);
        push_job(2, 3'd3, 32'hA000_0002, 1'b0);
        push_job(3, 3'd4, 32'hA000_0003, 1'b0);
        push_job(0, 3'd1, 32'hA000_0000, 1'b0);
        push_job(1, 3'd2, 32'hA000_0001, 1'b0);
        rst_n = 1'b1;
        wait_jobs(6, 400, "fair_jobs");

        // Single job from source 1 with a long controller busy period and mid-job withdrawal
        set_src(1, 3'd2, 32'h0000_4B41);
        ctl_hold = 40;
        push_job(1, 3'd2, 32'h0000_4B41, 1'b0);
        @(negedge clk);
        req[1] = 1'b1;
        starts = 0; td = -1; tr = -1; low_seen = 1'b0;
        for (int c = 0; c < 200 && td < 0; c++) begin
            @(negedge clk);
            if (c == 0) begin
                chk("t1_grant", 32'(grant), 32'h2);
                chk("t1_start_first", 32'(bc_start), 32'h1);
            end
            if (bc_start) starts++;
            if (!bc_ready) low_seen = 1'b1;
            else if (low_seen && tr < 0) tr = c;
            if (done[1]) td = c;
            if (c == 10) begin
                req[1] = 1'b0;
                set_src(1, 3'd7, 32'hFFFF_FFFF);
            end
            if (c == 12) chk("t1_tbuf_held", bc_tbuf, 32'h0000_4B41);
        end
        chk("t1_done_seen", 32'(td >= 0), 32'h1);
        chk("t1_start_cycles", 32'(starts), 32'd2);
        chk("t1_done_latency", 32'(td - tr), 32'd2);
        @(negedge clk);
        chk("t1_done_once", 32'(done), 32'h0);

        // Pointer now at 2: with 0 and 2 requesting, 2 goes first
        set_src(0, 3'd1, 32'h0000_0030);
        set_src(2, 3'd2, 32'h0000_0032);
        ctl_hold = 2;
        push_job(2, 3'd2, 32'h0000_0032, 1'b0);
        push_job(0, 3'd1, 32'h0000_0030, 1'b0);
        left[0] = 1; left[2] = 1;
        req[0] = 1'b1; req[2] = 1'b1;
        wait_jobs(2, 100, "ptr_jobs");

        // Zero-length job: no start, done two edges after req rises
        set_src(2, 3'd0, 32'h1234_5678);
        push_job(2, 3'd0, 32'h1234_5678, 1'b0);
        req[2] = 1'b1;
        starts = 0; td = -1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (bc_start) starts++;
            if (c == 1) chk("zl_grant", 32'(grant), 32'h4);
            if (done[2]) begin
                if (td < 0) td = c;
                req[2] = 1'b0;
            end
        end
        chk("zl_start_never", 32'(starts), 32'd0);
        chk("zl_done_latency", 32'(td), 32'd2);

        // Timeout on source 0, then source 1 serviced normally
        set_src(0, 3'd3, 32'hE0E0_E0E0);
        set_src(1, 3'd5, 32'h1122_3344);
        ctl_stuck = 1'b1;
        ctl_hold  = 4;
        push_job(0, 3'd3, 32'hE0E0_E0E0, 1'b1);
        push_job(1, 3'd5, 32'h1122_3344, 1'b0);
        req[0] = 1'b1; req[1] = 1'b1;
        starts = 0; got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            if (bc_start) starts++;
            if (err[0]) begin
                got = 1'b1;
                req[0] = 1'b0;
                ctl_stuck = 1'b0;
            end
        end
        chk("to_err_seen", 32'(got), 32'h1);
        chk("to_start_cycles", 32'(starts), 32'd8);
        left[1] = 1;
        wait_jobs(1, 100, "to_next_job");

        // Asynchronous reset during BUSY
        set_src(3, 3'd6, 32'h0000_0333);
        ctl_hold = 30;
        begin
            job_t j;
            j.src = 3; j.bc = 3'd6; j.tb = 32'h0000_0333; j.is_err = 1'b0;
            exp_grant.push_back(j);
        end
        req[3] = 1'b1;
        repeat (6) @(negedge clk);
        chk("ar_pre_busy", 32'(busy), 32'h1);
        chk("ar_pre_start", 32'(bc_start), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_grant", 32'(grant), 32'h0);
        chk("ar_done", 32'(done), 32'h0);
        chk("ar_err", 32'(err), 32'h0);
        chk("ar_start", 32'(bc_start), 32'h0);
        chk("ar_busy", 32'(busy), 32'h0);
        chk("ar_bcount", 32'(bc_bcount), 32'h0);
        chk("ar_tbuf", bc_tbuf, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        set_src(1, 3'd1, 32'h0000_0111);
        req[1] = 1'b1;
        push_job(1, 3'd1, 32'h0000_0111, 1'b0);
        push_job(3, 3'd6, 32'h0000_0333, 1'b0);
        left[1] = 1; left[3] = 1;
        @(negedge clk);
        chk("ar_hold_while_ctl_busy", 32'(grant), 32'h0);
        wait_jobs(2, 200, "ar_jobs");

        // Release masking: source 3 keeps req through its done, source 0 is next
        set_src(3, 3'd2, 32'h0000_0363);
        set_src(0, 3'd1, 32'h0000_0360);
        ctl_hold = 4;
        push_job(3, 3'd2, 32'h0000_0363, 1'b0);
        push_job(0, 3'd1, 32'h0000_0360, 1'b0);
        req[3] = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (c == 3) req[0] = 1'b1;
            if (done[3]) got = 1'b1;
        end
        chk("rm_done3_seen", 32'(got), 32'h1);
        @(negedge clk);
        chk("rm_next_grant", 32'(grant), 32'h1);
        req[3] = 1'b0;
        left[0] = 1;
        wait_jobs(1, 100, "rm_job0");

        // Sole requester held through done is masked for the release cycle
        set_src(2, 3'd3, 32'h0000_0222);
        ctl_hold = 2;
        push_job(2, 3'd3, 32'h0000_0222, 1'b0);
        push_job(2, 3'd3, 32'h0000_0222, 1'b0);
        req[2] = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (done[2]) got = 1'b1;
        end
        chk("mask_done_seen", 32'(got), 32'h1);
        @(negedge clk);
        chk("mask_idle_gap", 32'(grant), 32'h0);
        @(negedge clk);
        chk("mask_regrant", 32'(grant), 32'h4);
        req[2] = 1'b0;
        left[2] = 1;
        wait_jobs(1, 100, "mask_job2");

        repeat (3) @(negedge clk);
        chk("sb_grant_drained", 32'(exp_grant.size()), 32'h0);
        chk("sb_cmpl_drained", 32'(exp_cmpl.size()), 32'h0);
        sim_done = 1'b1;
    endtask

    initial begin
        fork
            monitor();
            stimulus();
        join
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
